// File: rtl/pipe_regfile_pkg.sv
// Shared types and default geometry for the pipelined register file and its
// bulk-clear sequencer.
package pipe_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Clear sequencer state: a plain 1-bit code so it can be probed directly.
  typedef logic [0:0] clrState_t;

  localparam clrState_t IDLE  = 1'b0;
  localparam clrState_t CLEAR = 1'b1;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks an index from 0 to NUM_REGS-1, one register per
// cycle, then returns to IDLE. The state is exported for probing.
module rf_clear_seq
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clrReq,
  output clrState_t         state,
  output logic [ADDR_W-1:0] clrIdx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] cntQ;

  // The counter stops at the last index and is parked at 0 on exit, so it
  // never wraps while the sequencer is walking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cntQ  <= '0;
    end else if (state == IDLE) begin
      if (clrReq) begin
        state <= CLEAR;
        cntQ  <= '0;
      end
    end else begin
      if (cntQ == LAST_IDX) begin
        state <= IDLE;
        cntQ  <= '0;
      end else begin
        cntQ <= cntQ + IDX_ONE;
      end
    end
  end

  assign clrIdx = cntQ;

endmodule

// File: rtl/pipe_regfile.sv
// Two-read / one-write register file with write bypass, an issue/writeback
// pending scoreboard and a sequenced bulk clear.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              pend1,
  output logic              pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // wr_en / iss_en / clr_req are single-cycle strobes with no backpressure:
  // each is consumed at the edge it is seen, and silently dropped while
  // clr_busy is high. There is no ready signal; callers watch clr_busy.

  logic [DATA_W-1:0]            memQ [NUM_REGS];
  logic [NUM_REGS-1:0]          pendQ;
  clrState_t                    clrState;
  logic [ADDR_W-1:0]            clrIdx;
  logic                         clrBusy;
  logic                         wrOk;
  logic                         issOk;
  logic [1:0][ADDR_W-1:0]       rdAddr;
  logic [1:0][DATA_W-1:0]       rdComb;
  logic [1:0][DATA_W-1:0]       rdOut;
  logic [1:0]                   pendOut;

  function automatic logic isZero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clearSeq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clrReq (clr_req),
    .state  (clrState),
    .clrIdx (clrIdx)
  );

  assign clrBusy  = (clrState == CLEAR);
  assign clr_busy = clrBusy;

  assign wrOk  = wr_en  & ~clrBusy & ~isZero(wr_addr);
  assign issOk = iss_en & ~clrBusy & ~isZero(iss_addr);

  // Issue is applied after writeback so a same-address pair leaves it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) memQ[i] <= '0;
      pendQ <= '0;
    end else if (clrBusy) begin
      memQ[clrIdx]  <= '0;
      pendQ[clrIdx] <= 1'b0;
    end else begin
      if (wrOk) begin
        memQ[wr_addr]  <= wr_data;
        pendQ[wr_addr] <= 1'b0;
      end
      if (issOk) pendQ[iss_addr] <= 1'b1;
    end
  end

  assign rdAddr[0] = rd_addr1;
  assign rdAddr[1] = rd_addr2;

  always_comb begin
    rdComb  = '0;
    pendOut = '0;
    for (int p = 0; p < 2; p++) begin
      rdComb[p]  = memQ[rdAddr[p]];
      pendOut[p] = pendQ[rdAddr[p]] & ~(wr_en && (wr_addr == rdAddr[p]));
      if (wrOk && (wr_addr == rdAddr[p])) rdComb[p] = wr_data;
      if (clrBusy || isZero(rdAddr[p])) begin
        rdComb[p]  = '0;
        pendOut[p] = 1'b0;
      end
    end
  end

  if (REG_READ != 0) begin : g_regRead
    logic [1:0][DATA_W-1:0] rdQ;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdQ <= '0;
      else        rdQ <= rdComb;
    end

    // The value captured on the edge into CLEAR is stale; mask it while busy.
    assign rdOut = clrBusy ? '0 : rdQ;
  end else begin : g_combRead
    assign rdOut = rdComb;
  end

  assign rd_data1 = rdOut[0];
  assign rd_data2 = rdOut[1];
  assign pend1    = pendOut[0];
  assign pend2    = pendOut[1];

endmodule

// File: tb/tb_pipe_regfile.sv
// Bench for pipe_regfile: one default instance and one with ZERO_REG=1,
// REG_READ=1, both fed the same stimulus and checked per cycle.
module tb_pipe_regfile;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int EW = 2 * DW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, iss_addr = '0;
  logic          wr_en = 1'b0, iss_en = 1'b0, clr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] aRd1, aRd2, bRd1, bRd2;
  logic          aPend1, aPend2, bPend1, bPend2, aBusy, bBusy;

  always #5 clk = ~clk;

  pipe_regfile dutA (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(aRd1), .rd_data2(aRd2), .pend1(aPend1), .pend2(aPend2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(aBusy)
  );

  pipe_regfile #(.ZERO_REG(1), .REG_READ(1)) dutB (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(bRd1), .rd_data2(bRd2), .pend1(bPend1), .pend2(bPend2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(bBusy)
  );

  // Expected tuple per cycle: {rd_data1, rd_data2, pend1, pend2, clr_busy}
  logic [EW-1:0] expA_q[$];
  logic [EW-1:0] expB_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  string phase = "init";

  // Reference model: index 0 is the default instance, index 1 the zero-reg one.
  logic [DW-1:0] mdlMem [2][NR];
  bit            mdlPend[2][NR];
  int            clrLeft[2];
  logic [DW-1:0] prevB1, prevB2;

  function automatic bit zr(input int m);
    return m == 1;
  endfunction

  function automatic logic [DW-1:0] expRd(input int m, input logic [AW-1:0] a);
    if (clrLeft[m] > 0) return '0;
    if (zr(m) && a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mdlMem[m][a];
  endfunction

  function automatic logic expPend(input int m, input logic [AW-1:0] a);
    if (clrLeft[m] > 0) return 1'b0;
    if (zr(m) && a == 0) return 1'b0;
    return mdlPend[m][a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic void modelEdge(input int m);
    int pos;
    if (clrLeft[m] > 0) begin
      pos = NR - clrLeft[m];
      mdlMem[m][pos]  = '0;
      mdlPend[m][pos] = 1'b0;
      clrLeft[m]--;
    end else begin
      if (wr_en && !(zr(m) && wr_addr == 0)) begin
        mdlMem[m][wr_addr]  = wr_data;
        mdlPend[m][wr_addr] = 1'b0;
      end
      if (iss_en && !(zr(m) && iss_addr == 0)) mdlPend[m][iss_addr] = 1'b1;
      if (clr_req) clrLeft[m] = NR;
    end
  endfunction

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NR; i++) begin
        mdlMem[m][i]  = '0;
        mdlPend[m][i] = 1'b0;
      end
      clrLeft[m] = 0;
    end
    prevB1 = '0;
    prevB2 = '0;
  endfunction

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit ie, input logic [AW-1:0] ia, input bit cr,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic [DW-1:0] nb1, nb2, eb1, eb2;
    bit busyA, busyB;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; clr_req = cr;
    rd_addr1 = r1; rd_addr2 = r2;
    busyA = clrLeft[0] > 0;
    busyB = clrLeft[1] > 0;
    expA_q.push_back({expRd(0, r1), expRd(0, r2), expPend(0, r1), expPend(0, r2), busyA});
    nb1 = expRd(1, r1);
    nb2 = expRd(1, r2);
    eb1 = busyB ? {DW{1'b0}} : prevB1;
    eb2 = busyB ? {DW{1'b0}} : prevB2;
    expB_q.push_back({eb1, eb2, expPend(1, r1), expPend(1, r2), busyB});
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    prevB1 = nb1;
    prevB2 = nb2;
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, r1, r2);
  endtask

  task automatic holdReset(input int n);
    rst_n = 1'b0;
    wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    modelReset();
    for (int i = 0; i < n; i++) begin
      expA_q.push_back({EW{1'b0}});
      expB_q.push_back({EW{1'b0}});
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic randCycle(input int clrOdds);
    drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, NR - 1)), DW'($urandom),
          $urandom_range(0, 2) == 0, AW'($urandom_range(0, NR - 1)),
          $urandom_range(0, clrOdds) == 0,
          AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
  endtask

  // Monitor: the DUT presents a result every cycle; compare mid-cycle.
  initial begin
    logic [EW-1:0] e, act;
    forever begin
      @(negedge clk);
      cyc++;
      if (expA_q.size() > 0) begin
        e   = expA_q.pop_front();
        act = {aRd1, aRd2, aPend1, aPend2, aBusy};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL dutA %s cyc=%0d got={rd1=%h rd2=%h p1=%b p2=%b busy=%b} want={rd1=%h rd2=%h p1=%b p2=%b busy=%b}",
                   phase, cyc, act[EW-1 -: DW], act[DW+2 -: DW], act[2], act[1], act[0],
                   e[EW-1 -: DW], e[DW+2 -: DW], e[2], e[1], e[0]);
        end
      end
      if (expB_q.size() > 0) begin
        e   = expB_q.pop_front();
        act = {bRd1, bRd2, bPend1, bPend2, bBusy};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL dutB %s cyc=%0d got={rd1=%h rd2=%h p1=%b p2=%b busy=%b} want={rd1=%h rd2=%h p1=%b p2=%b busy=%b}",
                   phase, cyc, act[EW-1 -: DW], act[DW+2 -: DW], act[2], act[1], act[0],
                   e[EW-1 -: DW], e[DW+2 -: DW], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    phase = "reset";
    holdReset(3);
    idle(5, 3);

    phase = "write_r5";
    drive(1'b1, 4'd5, 16'hBEEF, 1'b0, '0, 1'b0, 4'd5, 4'd0);
    idle(4'd5, 4'd5);
    idle(4'd5, 4'd0);

    phase = "bypass_r3";
    drive(1'b1, 4'd3, 16'h1234, 1'b0, '0, 1'b0, 4'd0, 4'd3);
    idle(4'd0, 4'd3);

    phase = "scoreboard_r7";
    drive(1'b0, '0, '0, 1'b1, 4'd7, 1'b0, 4'd7, 4'd7);
    idle(4'd7, 4'd7);
    drive(1'b1, 4'd7, 16'h0042, 1'b0, '0, 1'b0, 4'd7, 4'd7);
    idle(4'd7, 4'd7);
    drive(1'b1, 4'd7, 16'h0055, 1'b1, 4'd7, 1'b0, 4'd7, 4'd0);
    idle(4'd7, 4'd7);

    phase = "zero_reg";
    drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0);
    idle(4'd0, 4'd0);
    idle(4'd0, 4'd7);

    phase = "fill";
    for (int i = 0; i < NR; i++)
      drive(1'b1, AW'(i), DW'($urandom), i % 3 == 0, AW'(NR - 1 - i), 1'b0, AW'(i), AW'(i - 1));

    phase = "clear";
    drive(1'b1, 4'd9, 16'hA5A5, 1'b1, 4'd2, 1'b1, 4'd9, 4'd2);
    for (int i = 0; i < NR; i++) randCycle(1);
    phase = "after_clear";
    for (int i = 0; i < NR; i += 2) idle(AW'(i), AW'(i + 1));

    phase = "refill";
    for (int i = 0; i < NR; i++)
      drive(1'b1, AW'(i), DW'($urandom), 1'b1, AW'($urandom_range(0, NR - 1)), 1'b0, AW'(i), 4'd6);
    phase = "clear_abort";
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd1, 4'd2);
    for (int i = 0; i < 5; i++) randCycle(1);
    holdReset(2);
    phase = "after_abort";
    for (int i = 0; i < NR; i += 2) idle(AW'(i), AW'(i + 1));
    drive(1'b1, 4'd11, 16'hC0DE, 1'b0, '0, 1'b0, 4'd11, 4'd0);
    idle(4'd11, 4'd11);

    phase = "random";
    for (int i = 0; i < 400; i++) randCycle(39);
    for (int i = 0; i < NR + 2; i++) idle(AW'(i), AW'($urandom_range(0, NR - 1)));

    phase = "drain";
    idle(4'd0, 4'd0);
    for (int i = 0; i < 10 && (expA_q.size() > 0 || expB_q.size() > 0); i++) @(negedge clk);
    total++;
    if (expA_q.size() > 0 || expB_q.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d/%0d want=0/0", expA_q.size(), expB_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register index width; NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads 0, ignores writes, never goes pending.
REQ-004 SHALL have parameter REG_READ, default 0; 0 = combinational read, 1 = registered read with 1-cycle latency.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports rd_addr1 / rd_addr2  in  ADDR_W  read port 1/2 index.
REQ-008 SHALL have ports rd_data1 / rd_data2  out  DATA_W  read port 1/2 data.
REQ-009 SHALL have ports pend1 / pend2  out  1  pending flag of the register addressed by rd_addr1/rd_addr2.
REQ-010 SHALL have ports wr_en  in  1, wr_addr  in  ADDR_W, wr_data  in  DATA_W  writeback port.
REQ-011 SHALL have ports iss_en  in  1, iss_addr  in  ADDR_W  issue port; marks the destination register pending.
REQ-012 SHALL have ports clr_req  in  1  start a bulk clear; clr_busy  out  1  clear in progress.

Function
REQ-013 Write: when wr_en=1 and state IDLE, mem[wr_addr] SHALL take wr_data at the clock edge.
REQ-014 Bypass: a read of an address being written in the same cycle SHALL return wr_data, not the stale value (REG_READ=0: same cycle; REG_READ=1: on the next cycle).
REQ-015 REG_READ=1: rd_data SHALL be registered from rd_addr sampled at the edge; latency exactly 1 cycle.
REQ-016 Scoreboard: iss_en SHALL set pending[iss_addr]; wr_en SHALL clear pending[wr_addr]; both on the same address in the same cycle leave it set (issue wins).
REQ-017 pendN SHALL be combinational: pending[rd_addrN] & ~(wr_en & wr_addr==rd_addrN), so a same-cycle writeback is reported not pending.
REQ-018 ZERO_REG=1: writes and issues to index 0 SHALL be discarded; bypass SHALL NOT apply to index 0; rd_data for index 0 = 0, pend = 0.
REQ-019 FSM states SHALL be IDLE and CLEAR. IDLE->CLEAR on clr_req=1. CLEAR->IDLE after exactly NUM_REGS cycles.
REQ-020 In CLEAR, an ADDR_W-bit counter SHALL start at 0 and zero one register and its pending bit per cycle, incrementing by 1 with no wrap beyond NUM_REGS-1.
REQ-021 clr_busy SHALL be 1 exactly while the state is CLEAR (NUM_REGS cycles, starting the cycle after clr_req).
REQ-022 During CLEAR, wr_en, iss_en and clr_req SHALL be ignored; rd_data SHALL read 0; pend SHALL read 0.
REQ-023 A clr_req coincident with wr_en/iss_en in IDLE: the write/issue SHALL take effect, and the clear then overwrites it.

Reset
REQ-024 On rst_n=0 (asynchronous), all registers, all pending bits, the counter and the registered read outputs SHALL be 0, and the state SHALL be IDLE.
REQ-025 Reset asserted mid-CLEAR SHALL abort the clear immediately; clr_busy SHALL be 0 while reset is active.
REQ-026 After rst_n rises, the first write SHALL take effect on the first rising clock edge.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-028 The clear sequencer (FSM plus counter) SHALL be a single sub-module, rf_clear_seq; storage, bypass and scoreboard live in pipe_regfile.

Verification
REQ-029 Defaults: write 0xBEEF to r5, then read r5 the next cycle -> rd_data1=0xBEEF, pend1=0.
REQ-030 Same-cycle write 0x1234 to r3 with rd_addr2=3 -> rd_data2=0x1234 that cycle (REG_READ=0) or the next cycle (REG_READ=1).
REQ-031 iss r7; then read r7 -> pend1=1; wr r7=0x0042 with rd_addr1=7 -> pend1=0 that cycle; iss+wr r7 together -> pend stays 1.
REQ-032 ZERO_REG=1: write 0xFFFF to r0 and issue r0 -> rd_data=0, pend=0.
REQ-033 Fill all 16 registers, pulse clr_req -> clr_busy=1 for exactly 16 cycles, writes are ignored, then all reads return 0 with pend=0.
REQ-034 Assert rst_n=0 at clear cycle 5 -> clr_busy=0 immediately and all registers read 0 after release.
